// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;
  localparam int ITERS = 32;

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    DIV_RUN
  } state_t;

endpackage

// File: rtl/multdiv_twos_negate.sv
// Combinational two's-complement negation, used for operand magnitudes
// and for applying the result sign.
module twos_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = ~a + W'(1);

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide: radix-2 shift-add multiply and restoring
// divide on unsigned magnitudes, sign applied on the final iteration edge.
//
// state   | meaning
// IDLE    | no operation in flight, outputs hold the last delivered result
// MUL_RUN | shift-add multiply, one multiplier bit per cycle
// DIV_RUN | restoring divide, one quotient bit per cycle
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  import multdiv_pkg::state_t;
  import multdiv_pkg::IDLE;
  import multdiv_pkg::MUL_RUN;
  import multdiv_pkg::DIV_RUN;
  import multdiv_pkg::ITERS;
  import multdiv_pkg::INT_MIN;

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  // acc_hi:acc_lo is the product (multiply) or remainder:quotient (divide)
  logic [WIDTH-1:0] acc_hi, acc_hi_next;
  logic [WIDTH-1:0] acc_lo, acc_lo_next;
  logic [WIDTH-1:0] op_reg, op_reg_next;
  logic             res_neg, res_neg_next;
  logic [WIDTH-1:0] result_next;
  logic             exc_next;
  logic             rdy_next;

  logic [WIDTH-1:0] neg_a, neg_b, abs_a, abs_b;
  logic [WIDTH-1:0] fix_in, fix_neg, res_fixed;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic             mul_ovf;
  logic [WIDTH:0]   div_shift, div_diff;
  logic [WIDTH-1:0] div_rem, div_q;
  logic             div_ovf;
  logic             start_mul, start_div, is_last;

  twos_negate #(.W(WIDTH)) u_neg_a (.a(data_operandA), .y(neg_a));
  twos_negate #(.W(WIDTH)) u_neg_b (.a(data_operandB), .y(neg_b));
  twos_negate #(.W(WIDTH)) u_neg_r (.a(fix_in),        .y(fix_neg));

  assign abs_a = data_operandA[WIDTH-1] ? neg_a : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? neg_b : data_operandB;

  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_reg} : '0);
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};
  // A negative result may reach exactly -2^31; a positive one stops at 2^31-1.
  assign mul_ovf = res_neg ? ((|mul_hi) || (mul_lo[WIDTH-1] && (|mul_lo[WIDTH-2:0])))
                           : ((|mul_hi) || mul_lo[WIDTH-1]);

  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, op_reg};
  assign div_rem   = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign div_q     = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
  assign div_ovf   = !res_neg && (div_q == INT_MIN);

  assign fix_in    = (state == DIV_RUN) ? div_q : mul_lo;
  assign res_fixed = res_neg ? fix_neg : fix_in;

  assign start_mul = ctrl_MULT && !ctrl_DIV;
  assign start_div = ctrl_DIV && !ctrl_MULT;
  assign is_last   = (cnt == CNT_W'(ITERS - 1));
  assign busy      = (state != IDLE);

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    acc_hi_next  = acc_hi;
    acc_lo_next  = acc_lo;
    op_reg_next  = op_reg;
    res_neg_next = res_neg;
    result_next  = data_result;
    exc_next     = data_exception;
    rdy_next     = 1'b0;

    if (start_mul) begin
      state_next   = MUL_RUN;
      cnt_next     = '0;
      acc_hi_next  = '0;
      acc_lo_next  = abs_b;
      op_reg_next  = abs_a;
      res_neg_next = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
    end else if (start_div) begin
      if (data_operandB == '0) begin
        state_next  = IDLE;
        result_next = '0;
        exc_next    = 1'b1;
        rdy_next    = 1'b1;
      end else begin
        state_next   = DIV_RUN;
        cnt_next     = '0;
        acc_hi_next  = '0;
        acc_lo_next  = abs_a;
        op_reg_next  = abs_b;
        res_neg_next = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      end
    end else begin
      case (state)
        MUL_RUN: begin
          acc_hi_next = mul_hi;
          acc_lo_next = mul_lo;
          cnt_next    = cnt + CNT_W'(1);
          if (is_last) begin
            state_next  = IDLE;
            result_next = res_fixed;
            exc_next    = mul_ovf;
            rdy_next    = 1'b1;
          end
        end
        DIV_RUN: begin
          acc_hi_next = div_rem;
          acc_lo_next = div_q;
          cnt_next    = cnt + CNT_W'(1);
          if (is_last) begin
            state_next  = IDLE;
            result_next = res_fixed;
            exc_next    = div_ovf;
            rdy_next    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      acc_hi         <= '0;
      acc_lo         <= '0;
      op_reg         <= '0;
      res_neg        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      acc_hi         <= acc_hi_next;
      acc_lo         <= acc_lo_next;
      op_reg         <= op_reg_next;
      res_neg        <= res_neg_next;
      data_result    <= result_next;
      data_exception <= exc_next;
      data_resultRDY <= rdy_next;
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: vector table plus scoreboard of
// expected deliveries, with hand-written restart, abort and reset sequences.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] r;
    logic        e;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          is_div;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[14];
  int   passed = 0;
  int   total = 0;
  int   rdy_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clock) begin
    if (data_resultRDY === 1'b1) begin
      exp_t e;
      rdy_count++;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
      end else begin
        e = sb.pop_front();
        check("result", 64'(data_result), 64'(e.r));
        check("exception", 64'(data_exception), 64'(e.e));
        check("ready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  function automatic void model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    int     q;
    if (!is_div) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = q;
      e = 1'b0;
    end
  endfunction

  task automatic do_op(input string tag, input bit is_div, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_r, input logic exp_e);
    int t, lat, bad;
    exp_t e;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = !is_div;
    ctrl_DIV  = is_div;
    t   = cyc;
    lat = (is_div && b == 32'd0) ? 1 : 33;
    e.r = exp_r; e.e = exp_e; e.cyc = t + lat;
    sb.push_back(e);
    bad = 0;
    while (cyc < t + lat + 1) begin
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
      if (cyc <= t + lat && busy !== (cyc < t + lat)) bad++;
    end
    check({tag, "_drain"}, 64'(sb.size()), 64'd0);
    check({tag, "_busy"}, 64'(bad), 64'd0);
    check({tag, "_hold"}, {31'd0, data_exception, data_result}, {31'd0, exp_e, exp_r});
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int t, base, bad;
    exp_t e;
    logic [31:0] a, b, r;
    logic        ex;
    bit          dv;

    vecs[0]  = '{1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1};
    vecs[2]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[3]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
    vecs[4]  = '{1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};
    vecs[5]  = '{1'b1, 32'd5,          32'd0,         32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[7]  = '{1'b0, 32'd0,          32'hFFFF_FFFB, 32'h0000_0000, 1'b0};
    vecs[8]  = '{1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0};
    vecs[9]  = '{1'b1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0};
    vecs[10] = '{1'b0, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h0000_0001, 1'b1};
    vecs[11] = '{1'b1, 32'd7,          32'd100,       32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 32'hFFFF_0000,  32'h0000_8000, 32'h8000_0000, 1'b0};
    vecs[13] = '{1'b0, 32'hFFFF_0000,  32'h0000_8001, 32'h7FFF_0000, 1'b1};

    reset = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (3) @(negedge clock);
    check("reset_result", 64'(data_result), 64'd0);
    check("reset_exception", 64'(data_exception), 64'd0);
    check("reset_ready", 64'(data_resultRDY), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 14; i++)
      do_op($sformatf("vec%0d", i), vecs[i].is_div, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].e);

    for (int i = 0; i < 8; i++) begin
      dv = $urandom_range(1, 0) == 1;
      a  = (i < 4) ? $urandom : 32'($signed($urandom_range(2000, 0)) - 1000);
      b  = (i < 4) ? 32'($signed($urandom_range(200, 0)) - 100) : $urandom;
      model(dv, a, b, r, ex);
      do_op($sformatf("rnd%0d", i), dv, a, b, r, ex);
    end

    // restart: divide issued mid-multiply replaces it
    base = rdy_count;
    @(negedge clock);
    data_operandA = 32'd3; data_operandB = 32'd4; ctrl_MULT = 1'b1;
    t = cyc;
    while (cyc < t + 10) begin
      @(negedge clock);
      ctrl_MULT = 1'b0;
    end
    data_operandA = 32'd100; data_operandB = 32'd7; ctrl_DIV = 1'b1;
    e.r = 32'd14; e.e = 1'b0; e.cyc = t + 43;
    sb.push_back(e);
    while (cyc < t + 44) begin
      @(negedge clock);
      ctrl_DIV = 1'b0;
    end
    check("restart_drain", 64'(sb.size()), 64'd0);
    check("restart_ready_count", 64'(rdy_count - base), 64'd1);
    sb.delete();

    // both start lines together are ignored
    base = rdy_count;
    bad = 0;
    @(negedge clock);
    data_operandA = 32'd6; data_operandB = 32'd3; ctrl_MULT = 1'b1; ctrl_DIV = 1'b1;
    repeat (40) begin
      @(negedge clock);
      ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      if (busy !== 1'b0) bad++;
    end
    check("both_ready_count", 64'(rdy_count - base), 64'd0);
    check("both_busy", 64'(bad), 64'd0);

    // reset mid-multiply
    @(negedge clock);
    data_operandA = 32'h1234; data_operandB = 32'h5678; ctrl_MULT = 1'b1;
    t = cyc;
    while (cyc < t + 20) begin
      @(negedge clock);
      ctrl_MULT = 1'b0;
    end
    reset = 1'b0;
    @(negedge clock);
    check("midrst_result", 64'(data_result), 64'd0);
    check("midrst_exception", 64'(data_exception), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(data_resultRDY), 64'd0);
    base = rdy_count;
    reset = 1'b1;
    repeat (40) @(negedge clock);
    check("midrst_ready_count", 64'(rdy_count - base), 64'd0);
    do_op("after_reset", 1'b0, 32'd2, 32'd2, 32'd4, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
